prog_run_ctrl: RTL and testbench
================================

Name: prog_run_ctrl

Overview:
- Run controller that sequences the single-cycle core through one program execution.
- Launches the core at a captured start address by pulsing the IF stage's Start/Start_Addr.
- Gates execution with a run enable, counts executed instructions, and terminates on a decoded halt or an instruction-count limit.
- Supports pause and single-step for bench and debug use; sits between the testbench/host and the core's fetch and write-enable paths.

Parameters:
- PC_W, 8, width of PC and start address.
- CNT_W, 16, width of the instruction counter.
- MAX_INSTR, 16'hFFFF, instruction-count limit that forces termination.

Ports:
- CLK  in  1  clock, all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Go  in  1  request a run; sampled only in IDLE.
- StartAddr  in  PC_W  program entry address; captured when Go is accepted.
- Pause  in  1  level; hold the core while high during a run.
- Step  in  1  pulse; execute exactly one instruction while paused.
- Halt  in  1  decoded halt opcode from Control for the current instruction.
- PC  in  PC_W  current PC from IF.
- Start  out  1  to IF Start; high for exactly one cycle per accepted run.
- Start_Addr  out  PC_W  to IF Start_Addr; holds the captured address.
- RunEn  out  1  core enable; gates PC update, register write and memory write.
- Busy  out  1  high from Go acceptance until DONE exits.
- Done  out  1  one-cycle pulse at run end.
- TimedOut  out  1  sticky until next Go; run ended by MAX_INSTR.
- InstrCount  out  CNT_W  instructions executed (RunEn-high cycles) in this run.

Behaviour:
- States: IDLE, LAUNCH, RUN, PAUSED, DONE.
- Reset (any state, any cycle) -> IDLE.
  - Reset values: Start=0, Start_Addr=0, RunEn=0, Busy=0, Done=0, TimedOut=0, InstrCount=0.
  - A mid-run reset abandons the run with no Done pulse.
- IDLE:
  - Outputs Busy=0, RunEn=0.
  - On Go=1: capture StartAddr, clear InstrCount and TimedOut, go to LAUNCH.
- LAUNCH (1 cycle):
  - Start=1, Busy=1, RunEn=0.
  - Next state is RUN, or PAUSED if Pause=1.
- RUN:
  - RunEn=1 and InstrCount increments by 1 every cycle.
  - Pause=1: transition to PAUSED. RunEn is deasserted combinationally in that same cycle, and no instruction or count occurs that cycle.
  - Halt=1 with RunEn=1: the halt instruction is counted; go to DONE.
  - Limit: if InstrCount reaches MAX_INSTR after the increment and Halt=0, set TimedOut=1 and go to DONE.
  - Halt and limit in the same cycle: Halt wins, TimedOut stays 0.
- PAUSED:
  - RunEn=0 and the count is held.
  - Step=1: RunEn=1 for that cycle only and the count increments. Halt on the stepped cycle still goes to DONE, and the limit still applies.
  - Pause=0 and Step=0: return to RUN next cycle.
  - Step while Pause=0 in PAUSED: treated as a normal resume cycle.
- DONE (1 cycle):
  - Done=1, RunEn=0, Busy=1; then IDLE.
  - InstrCount and TimedOut hold until the next accepted Go.
- Ignored inputs:
  - Go is ignored outside IDLE.
  - Halt is ignored whenever RunEn=0.
  - Step is ignored outside PAUSED.
- Counter arithmetic: unsigned; cannot wrap, because the limit terminates the run first.

Optional Feature:
- Macro PROG_RUN_CTRL_BKPT_EN.
- Defined:
  - Adds inputs BkptAddr (PC_W) and BkptArm (1), and output BkptHit (1, sticky until next Go, reset 0).
  - In RUN with BkptArm=1 and PC==BkptAddr: RunEn=0 that cycle (instruction not executed, not counted), BkptHit=1, go to PAUSED.
  - The first Step or resume after a hit executes the breakpoint instruction without re-triggering on the same PC.
- Undefined: the ports do not exist and there is no breakpoint logic.

Test Plan:
- Reset, then Go with StartAddr=8'h10, Halt on the 5th RunEn cycle -> Start high 1 cycle with Start_Addr=8'h10; Done pulse 1 cycle later; InstrCount=5; TimedOut=0.
- MAX_INSTR=16'd20, Halt never asserted -> exactly 20 RunEn cycles; TimedOut=1; InstrCount=20; Done pulse.
- Pause high for cycles 3–7 of a run, then 2 Step pulses, then Pause low; halt at count 10 -> RunEn low throughout the pause except the 2 step cycles; final InstrCount=10.
- Go pulsed during RUN and during DONE; Reset asserted mid-run at count 7 -> Go ignored while busy; after reset all outputs 0; next Go starts a fresh run from count 0 with no Done for the aborted run.
- MAX_INSTR=16'd3, Halt asserted on the 3rd instruction -> TimedOut=0; InstrCount=3; Done pulse.
- (PROG_RUN_CTRL_BKPT_EN) BkptArm=1, BkptAddr=8'h14, start at 8'h10 -> pause with PC=8'h14 and InstrCount=4; BkptHit=1; one Step executes the breakpoint instruction; InstrCount=5; no re-hit.

Source files
------------

// File: rtl/prog_run_ctrl.sv
// prog_run_ctrl: run controller that launches the core at a captured start
// address, gates execution through RunEn, counts executed instructions and
// ends the run on a decoded halt or on reaching MAX_INSTR. Pause and
// single-step allow debug control of a run.
// Optional breakpoint support is compiled in with `define PROG_RUN_CTRL_BKPT_EN.
module prog_run_ctrl #(
  parameter int PC_W = 8,
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] MAX_INSTR = 16'hFFFF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Go,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Pause,
  input  logic             Step,
  input  logic             Halt,
  input  logic [PC_W-1:0]  PC,
`ifdef PROG_RUN_CTRL_BKPT_EN
  input  logic [PC_W-1:0]  BkptAddr,
  input  logic             BkptArm,
  output logic             BkptHit,
`endif
  output logic             Start,
  output logic [PC_W-1:0]  Start_Addr,
  output logic             RunEn,
  output logic             Busy,
  output logic             Done,
  output logic             TimedOut,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, PAUSED, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             at_limit;
  logic             run_en;
  logic             bkpt_trig;

`ifdef PROG_RUN_CTRL_BKPT_EN
  logic bkpt_skip;

  // A breakpoint fires in RUN on a PC match, unless we are resuming onto the
  // very instruction that caused the previous hit.
  assign bkpt_trig = (state == RUN) && BkptArm && (PC == BkptAddr) && !bkpt_skip;
`else
  logic unused_pc;

  // PC is only consumed by the breakpoint compare.
  assign unused_pc = ^PC;
  assign bkpt_trig = 1'b0;
`endif

  assign count_inc = count + CNT_W'(1);
  assign at_limit  = (count_inc == MAX_INSTR);

  // RunEn must drop in the same cycle Pause rises or a breakpoint fires, so it
  // is decoded from the current state and inputs rather than registered.
  always_comb begin
    run_en = 1'b0;
    case (state)
      RUN:     run_en = !Pause && !bkpt_trig;
      PAUSED:  run_en = Pause && Step;
      default: run_en = 1'b0;
    endcase
  end

  assign RunEn      = run_en;
  assign InstrCount = count;

  // Run sequencing: state, registered pulses, captured address and counters.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      Start      <= 1'b0;
      Start_Addr <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      TimedOut   <= 1'b0;
      count      <= '0;
`ifdef PROG_RUN_CTRL_BKPT_EN
      BkptHit    <= 1'b0;
      bkpt_skip  <= 1'b0;
`endif
    end else begin
      Start <= 1'b0;
      Done  <= 1'b0;
      case (state)
        IDLE: begin
          if (Go) begin
            Start_Addr <= StartAddr;
            count      <= '0;
            TimedOut   <= 1'b0;
            Start      <= 1'b1;
            Busy       <= 1'b1;
`ifdef PROG_RUN_CTRL_BKPT_EN
            BkptHit    <= 1'b0;
            bkpt_skip  <= 1'b0;
`endif
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= Pause ? PAUSED : RUN;
        end
        RUN, PAUSED: begin
          if (run_en) begin
            count <= count_inc;
`ifdef PROG_RUN_CTRL_BKPT_EN
            bkpt_skip <= 1'b0;
`endif
            if (Halt) begin
              Done  <= 1'b1;
              state <= DONE;
            end else if (at_limit) begin
              TimedOut <= 1'b1;
              Done     <= 1'b1;
              state    <= DONE;
            end
          end else if (state == RUN) begin
            state <= PAUSED;
`ifdef PROG_RUN_CTRL_BKPT_EN
            if (bkpt_trig) begin
              BkptHit   <= 1'b1;
              bkpt_skip <= 1'b1;
            end
`endif
          end else if (!Pause) begin
            state <= RUN;
          end
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// tb_prog_run_ctrl: self-checking bench for prog_run_ctrl. A small core model
// supplies PC (loaded by Start, advanced by RunEn) and drives Halt when PC
// reaches a chosen address. A behavioural model of the run rules is compared
// against the DUT every cycle; directed scenarios pin literal results.
module tb_prog_run_ctrl;

  localparam int MAX_I = 20;

  logic        CLK = 1'b0;
  logic        Reset, Go, Pause, Step, Halt;
  logic [7:0]  StartAddr, PC;
  logic        Start, RunEn, Busy, Done, TimedOut;
  logic [7:0]  Start_Addr;
  logic [15:0] InstrCount;
`ifdef PROG_RUN_CTRL_BKPT_EN
  logic [7:0]  BkptAddr;
  logic        BkptArm;
  logic        BkptHit;
`endif

  always #5 CLK = ~CLK;

  prog_run_ctrl #(.PC_W(8), .CNT_W(16), .MAX_INSTR(16'd20)) dut (
    .CLK(CLK), .Reset(Reset), .Go(Go), .StartAddr(StartAddr), .Pause(Pause),
    .Step(Step), .Halt(Halt), .PC(PC),
`ifdef PROG_RUN_CTRL_BKPT_EN
    .BkptAddr(BkptAddr), .BkptArm(BkptArm), .BkptHit(BkptHit),
`endif
    .Start(Start), .Start_Addr(Start_Addr), .RunEn(RunEn), .Busy(Busy),
    .Done(Done), .TimedOut(TimedOut), .InstrCount(InstrCount)
  );

  int   checks = 0;
  int   errors = 0;
  logic check_en = 1'b0;

  logic       halt_armed = 1'b0;
  logic [7:0] halt_pc = 8'h00;

  logic        s_start, s_run, s_done, s_to, s_busy, s_hit;
  logic [7:0]  s_addr;
  logic [15:0] s_count;
  int          run_cycles, start_pulses;
  logic        done_seen;

  // Behavioural model of the run rules.
  logic m_busy = 1'b0, m_start = 1'b0, m_done = 1'b0, m_paused = 1'b0;
  logic m_to = 1'b0, m_hit = 1'b0, m_skip = 1'b0;
  int   m_count = 0;
  logic [7:0] m_addr = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compare the DUT with the model on every falling edge, then advance the
  // model by one clock using the inputs that are stable for this cycle.
  always @(negedge CLK) begin
    logic exp_run;
    logic bk;
    bk = 1'b0;
`ifdef PROG_RUN_CTRL_BKPT_EN
    bk = m_busy && !m_start && !m_done && !m_paused && BkptArm && (PC == BkptAddr) && !m_skip;
`endif
    if (!m_busy || m_start || m_done) exp_run = 1'b0;
    else if (m_paused)                exp_run = Pause && Step;
    else                              exp_run = !Pause && !bk;

    if (check_en) begin
      checkOutput("RunEn", RunEn, exp_run);
      checkOutput("Start", Start, m_start);
      checkOutput("Start_Addr", Start_Addr, m_addr);
      checkOutput("Busy", Busy, m_busy);
      checkOutput("Done", Done, m_done);
      checkOutput("TimedOut", TimedOut, m_to);
      checkOutput("InstrCount", InstrCount, m_count);
`ifdef PROG_RUN_CTRL_BKPT_EN
      checkOutput("BkptHit", BkptHit, m_hit);
`endif
    end

    if (Reset) begin
      m_busy <= 0; m_start <= 0; m_done <= 0; m_paused <= 0;
      m_to <= 0; m_hit <= 0; m_skip <= 0; m_count <= 0; m_addr <= 8'h00;
    end else if (!m_busy) begin
      if (Go) begin
        m_busy <= 1; m_start <= 1; m_addr <= StartAddr; m_count <= 0;
        m_to <= 0; m_hit <= 0; m_skip <= 0; m_paused <= 0;
      end
    end else if (m_start) begin
      m_start <= 0;
      m_paused <= Pause;
    end else if (m_done) begin
      m_done <= 0;
      m_busy <= 0;
    end else if (exp_run) begin
      m_count <= m_count + 1;
      m_skip <= 0;
      if (Halt) begin
        m_done <= 1; m_paused <= 0;
      end else if (m_count + 1 == MAX_I) begin
        m_to <= 1; m_done <= 1; m_paused <= 0;
      end
    end else if (!m_paused) begin
      m_paused <= 1;
      if (bk) begin
        m_hit <= 1; m_skip <= 1;
      end
    end else if (!Pause) begin
      m_paused <= 0;
    end
  end

  // Sample the cycle in flight, then drive the next cycle's inputs and let the
  // core model advance PC.
  task automatic applyStimulus(input logic go, input logic [7:0] addr, input logic pause,
                               input logic step, input logic rst);
    @(negedge CLK);
    s_start = Start; s_run = RunEn; s_done = Done; s_count = InstrCount;
    s_to = TimedOut; s_busy = Busy; s_addr = Start_Addr; s_hit = 1'b0;
`ifdef PROG_RUN_CTRL_BKPT_EN
    s_hit = BkptHit;
`endif
    if (s_run) run_cycles++;
    if (s_start) start_pulses++;
    if (s_done) done_seen = 1'b1;
    @(posedge CLK);
    #1;
    if (s_start) PC = s_addr;
    else if (s_run) PC = PC + 8'd1;
    Go = go; StartAddr = addr; Pause = pause; Step = step; Reset = rst;
    Halt = halt_armed && (PC == halt_pc);
  endtask

  task automatic waitDone(input int max, input logic go, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      applyStimulus(go, 8'h10, 1'b0, 1'b0, 1'b0);
      if (s_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput({name, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    Reset = 1'b1; Go = 1'b0; Pause = 1'b0; Step = 1'b0; Halt = 1'b0;
    StartAddr = 8'h00; PC = 8'h00;
`ifdef PROG_RUN_CTRL_BKPT_EN
    BkptAddr = 8'h00; BkptArm = 1'b0;
`endif
    run_cycles = 0; start_pulses = 0; done_seen = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 1);
    check_en = 1'b1;
    applyStimulus(0, 8'h00, 0, 0, 0);
    $display("[TB] reset state");
    checkOutput("rst_busy", s_busy, 0);
    checkOutput("rst_count", s_count, 0);
    checkOutput("rst_addr", s_addr, 0);

    // Halt on the fifth instruction.
    $display("[TB] halt on 5th instruction");
    halt_armed = 1'b1; halt_pc = 8'h14;
    applyStimulus(1, 8'h10, 0, 0, 0);
    run_cycles = 0; start_pulses = 0;
    waitDone(40, 0, "t1");
    checkOutput("t1_count", s_count, 5);
    checkOutput("t1_model_count", m_count, 5);
    checkOutput("t1_timedout", s_to, 0);
    checkOutput("t1_start_pulses", start_pulses, 1);
    checkOutput("t1_start_addr", s_addr, 8'h10);
    checkOutput("t1_run_cycles", run_cycles, 5);
    applyStimulus(0, 8'h10, 0, 0, 0);
    checkOutput("t1_done_width", s_done, 0);

    // No halt: the instruction limit ends the run.
    $display("[TB] instruction limit");
    halt_armed = 1'b0;
    applyStimulus(1, 8'h10, 0, 0, 0);
    run_cycles = 0;
    waitDone(60, 0, "t2");
    checkOutput("t2_count", s_count, 20);
    checkOutput("t2_timedout", s_to, 1);
    checkOutput("t2_run_cycles", run_cycles, 20);

    // Pause over run cycles 3-7, two steps, then resume; halt at count 10.
    $display("[TB] pause and step");
    halt_armed = 1'b1; halt_pc = 8'h19;
    applyStimulus(1, 8'h10, 0, 0, 0);
    applyStimulus(0, 8'h10, 0, 0, 0);
    run_cycles = 0;
    applyStimulus(0, 8'h10, 0, 0, 0);
    applyStimulus(0, 8'h10, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 8'h10, 1, 0, 0);
    checkOutput("t3_runs_before_pause", run_cycles, 2);
    applyStimulus(0, 8'h10, 1, 1, 0);
    applyStimulus(0, 8'h10, 1, 0, 0);
    applyStimulus(0, 8'h10, 1, 1, 0);
    applyStimulus(0, 8'h10, 1, 0, 0);
    checkOutput("t3_runs_through_pause", run_cycles, 4);
    waitDone(40, 0, "t3");
    checkOutput("t3_count", s_count, 10);
    checkOutput("t3_timedout", s_to, 0);

    // Go held through RUN and DONE, then a reset abandons a run at count 7.
    $display("[TB] go while busy and mid-run reset");
    halt_armed = 1'b1; halt_pc = 8'h12;
    applyStimulus(1, 8'h10, 0, 0, 0);
    start_pulses = 0;
    waitDone(40, 1, "t4");
    checkOutput("t4_start_pulses", start_pulses, 1);
    checkOutput("t4_count", s_count, 3);
    halt_armed = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 8'h10, 0, 0, 0);
      if (s_count == 16'd5 && s_run) break;
    end
    applyStimulus(0, 8'h10, 0, 0, 1);
    applyStimulus(0, 8'h10, 0, 0, 0);
    checkOutput("t4_count_at_reset", s_count, 7);
    applyStimulus(0, 8'h10, 0, 0, 0);
    checkOutput("t4_post_busy", s_busy, 0);
    checkOutput("t4_post_count", s_count, 0);
    checkOutput("t4_post_addr", s_addr, 0);
    checkOutput("t4_post_start", s_start, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h10, 0, 0, 0);
    checkOutput("t4_no_done", done_seen, 0);
    halt_armed = 1'b1; halt_pc = 8'h12;
    applyStimulus(1, 8'h10, 0, 0, 0);
    waitDone(40, 0, "t4b");
    checkOutput("t4b_count", s_count, 3);

    // Halt and limit on the same instruction: halt wins.
    $display("[TB] halt at limit");
    halt_armed = 1'b1; halt_pc = 8'h23;
    applyStimulus(1, 8'h10, 0, 0, 0);
    waitDone(60, 0, "t5");
    checkOutput("t5_count", s_count, 20);
    checkOutput("t5_timedout", s_to, 0);

`ifdef PROG_RUN_CTRL_BKPT_EN
    // Breakpoint at 0x14, stepped over, then halt at 0x17.
    $display("[TB] breakpoint");
    halt_armed = 1'b0;
    BkptArm = 1'b1; BkptAddr = 8'h14;
    applyStimulus(1, 8'h10, 0, 0, 0);
    applyStimulus(0, 8'h10, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h10, 0, 0, 0);
    applyStimulus(0, 8'h10, 1, 0, 0);
    applyStimulus(0, 8'h10, 1, 0, 0);
    applyStimulus(0, 8'h10, 1, 0, 0);
    checkOutput("bk_hit", s_hit, 1);
    checkOutput("bk_count", s_count, 4);
    checkOutput("bk_pc", PC, 8'h14);
    applyStimulus(0, 8'h10, 1, 1, 0);
    applyStimulus(0, 8'h10, 1, 0, 0);
    applyStimulus(0, 8'h10, 1, 0, 0);
    checkOutput("bk_step_count", s_count, 5);
    halt_armed = 1'b1; halt_pc = 8'h17;
    waitDone(40, 0, "bk");
    checkOutput("bk_final_count", s_count, 8);
    BkptArm = 1'b0;
`endif

    // Randomised traffic checked by the model every cycle.
    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      if (i % 25 == 0) begin
        halt_armed = 1'($urandom_range(1));
        halt_pc = 8'h10 + 8'($urandom_range(24));
`ifdef PROG_RUN_CTRL_BKPT_EN
        BkptArm = 1'($urandom_range(1));
        BkptAddr = 8'h10 + 8'($urandom_range(12));
`endif
      end
      applyStimulus(($urandom_range(3) == 0), 8'h10 + 8'($urandom_range(3)),
                    ($urandom_range(3) == 0), 1'($urandom_range(1)),
                    ($urandom_range(79) == 0));
    end
    applyStimulus(0, 8'h10, 0, 0, 0);
    applyStimulus(0, 8'h10, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
